// File: rtl/aes_arb_pkg.sv
// ============================================================================
// Module   : aes_arb_pkg
// Brief    : Shared widths and arbiter state encoding for aes_engine_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package aes_arb_pkg;

    localparam int AES_KEY_W = 256;
    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWITCH = 2'd1,
        ACTIVE = 2'd2,
        DRAIN  = 2'd3
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/aes_arb_rr.sv
// ============================================================================
// Module   : aes_arb_rr
// Brief    : Two-way round-robin picker; a contest goes to the non-last owner.
// Revision : 1.0
// ============================================================================
`default_nettype none

module aes_arb_rr (
    input  logic [1:0] i_req,
    input  logic       i_last_owner,
    input  logic       i_last_valid,
    output logic       o_winner
);

    always_comb begin
        o_winner = i_last_owner;
        case (i_req)
            2'b01:   o_winner = 1'b0;
            2'b10:   o_winner = 1'b1;
            // With no ownership history yet, requester 0 takes the first contest.
            2'b11:   o_winner = i_last_valid ? ~i_last_owner : 1'b0;
            default: o_winner = i_last_owner;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/aes_engine_arbiter.sv
// ============================================================================
// Module   : aes_engine_arbiter
// Brief    : Shares one aes256_fifo engine between two requesters, draining and
//            resetting the engine on every ownership change.
//            Optional statistics counters: define AES_ARB_STATS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module aes_engine_arbiter
    import aes_arb_pkg::*;
#(
    parameter int MAX_BURST  = 16,
    parameter int RST_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req,
    output logic [1:0]             gnt,
    input  logic [2*AES_KEY_W-1:0] r_key,
    input  logic [2*AES_BLK_W-1:0] r_ctr,
    input  logic [1:0]             r_in_valid,
    output logic [1:0]             r_in_ready,
    input  logic [2*AES_BLK_W-1:0] r_in_block,
    output logic [1:0]             r_out_valid,
    input  logic [1:0]             r_out_ready,
    output logic [AES_BLK_W-1:0]   r_out_block,
    output logic [AES_KEY_W-1:0]   aes_key,
    output logic [AES_BLK_W-1:0]   aes_ctr,
    output logic                   aes_in_valid,
    input  logic                   aes_in_ready,
    output logic [AES_BLK_W-1:0]   aes_in_block,
    input  logic                   aes_out_valid,
    output logic                   aes_out_ready,
    input  logic [AES_BLK_W-1:0]   aes_out_block,
    input  logic                   aes_fifo_empty,
    output logic                   aes_rst
`ifdef AES_ARB_STATS_EN
    ,
    output logic [31:0]            blk_cnt0,
    output logic [31:0]            blk_cnt1,
    output logic [15:0]            switch_cnt
`endif
);

    localparam logic [7:0] c_max_burst  = 8'(MAX_BURST);
    localparam logic [7:0] c_max_less1  = 8'(MAX_BURST - 1);
    localparam logic [3:0] c_rst_last   = 4'(RST_CYCLES - 1);

    arb_state_t r_state;
    arb_state_t w_next_state;
    logic       r_owner;
    logic       w_next_owner;
    logic       r_owned;
    logic       r_aes_rst;
    logic [3:0] r_rst_cnt;
    logic [7:0] r_burst;

    logic       w_other;
    logic       w_winner;
    logic       w_in_open;
    logic       w_out_open;
    logic       w_in_hs;
    logic       w_saturated;
    logic       w_enter_switch;

    aes_arb_rr u_rr (
        .i_req        (req),
        .i_last_owner (r_owner),
        .i_last_valid (r_owned),
        .o_winner     (w_winner)
    );

    assign w_other     = ~r_owner;
    assign w_saturated = (r_burst == c_max_burst);
    // Once saturated with the other side waiting, stop taking blocks so each grant is exactly MAX_BURST.
    assign w_in_open   = (r_state == ACTIVE) && !(w_saturated && req[w_other]);
    assign w_out_open  = (r_state == ACTIVE) || (r_state == DRAIN);
    assign w_in_hs     = aes_in_valid & aes_in_ready;

    assign aes_key      = r_owner ? r_key[2*AES_KEY_W-1:AES_KEY_W] : r_key[AES_KEY_W-1:0];
    assign aes_ctr      = r_owner ? r_ctr[2*AES_BLK_W-1:AES_BLK_W] : r_ctr[AES_BLK_W-1:0];
    assign aes_in_block = r_owner ? r_in_block[2*AES_BLK_W-1:AES_BLK_W] : r_in_block[AES_BLK_W-1:0];
    assign aes_in_valid = w_in_open & r_in_valid[r_owner];
    assign aes_out_ready = w_out_open & r_out_ready[r_owner];
    assign r_out_block  = aes_out_block;
    assign aes_rst      = r_aes_rst;
    assign gnt          = w_out_open ? (r_owner ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        r_in_ready  = 2'b00;
        r_out_valid = 2'b00;
        if (w_in_open) begin
            r_in_ready[r_owner] = aes_in_ready;
        end
        if (w_out_open) begin
            r_out_valid[r_owner] = aes_out_valid;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_owner = r_owner;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_next_owner = w_winner;
                    w_next_state = SWITCH;
                end
            end
            SWITCH: begin
                if (r_rst_cnt == c_rst_last) begin
                    w_next_state = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!req[r_owner] ||
                    (req[w_other] && (w_saturated || (w_in_hs && r_burst == c_max_less1)))) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (aes_fifo_empty && !aes_out_valid) begin
                    if (|req) begin
                        w_next_owner = w_winner;
                        w_next_state = SWITCH;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_enter_switch = (w_next_state == SWITCH) && (r_state != SWITCH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_owner   <= 1'b0;
            r_owned   <= 1'b0;
            r_aes_rst <= 1'b1;
            r_rst_cnt <= 4'd0;
            r_burst   <= 8'd0;
        end else begin
            r_state   <= w_next_state;
            r_owner   <= w_next_owner;
            r_aes_rst <= (w_next_state == SWITCH);
            if (w_enter_switch) begin
                r_owned <= 1'b1;
            end
            r_rst_cnt <= (r_state == SWITCH) ? r_rst_cnt + 4'd1 : 4'd0;
            if (r_state == SWITCH) begin
                r_burst <= 8'd0;
            end else if (w_in_hs && !w_saturated) begin
                r_burst <= r_burst + 8'd1;
            end
        end
    end

`ifdef AES_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt0   <= 32'd0;
            blk_cnt1   <= 32'd0;
            switch_cnt <= 16'd0;
        end else begin
            if (w_in_hs && !r_owner) begin
                blk_cnt0 <= blk_cnt0 + 32'd1;
            end
            if (w_in_hs && r_owner) begin
                blk_cnt1 <= blk_cnt1 + 32'd1;
            end
            if (w_enter_switch) begin
                switch_cnt <= switch_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_aes_engine_arbiter.sv
// ============================================================================
// Module   : tb_aes_engine_arbiter
// Brief    : Scoreboard bench for aes_engine_arbiter with a stand-in engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_aes_engine_arbiter;
    import aes_arb_pkg::*;

    localparam int MAXB = 2;
    localparam int RSTC = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [1:0]             req = 2'b00;
    logic [1:0]             gnt;
    logic [2*AES_KEY_W-1:0] r_key = '0;
    logic [2*AES_BLK_W-1:0] r_ctr = '0;
    logic [1:0]             r_in_valid = 2'b00;
    logic [1:0]             r_in_ready;
    logic [2*AES_BLK_W-1:0] r_in_block = '0;
    logic [1:0]             r_out_valid;
    logic [1:0]             r_out_ready = 2'b11;
    logic [AES_BLK_W-1:0]   r_out_block;
    logic [AES_KEY_W-1:0]   aes_key;
    logic [AES_BLK_W-1:0]   aes_ctr;
    logic                   aes_in_valid;
    logic                   aes_in_ready;
    logic [AES_BLK_W-1:0]   aes_in_block;
    logic                   aes_out_valid;
    logic                   aes_out_ready;
    logic [AES_BLK_W-1:0]   aes_out_block;
    logic                   aes_fifo_empty;
    logic                   aes_rst;
`ifdef AES_ARB_STATS_EN
    logic [31:0]            blk_cnt0;
    logic [31:0]            blk_cnt1;
    logic [15:0]            switch_cnt;
`endif

    always #5 clk = ~clk;

    aes_engine_arbiter #(.MAX_BURST(MAXB), .RST_CYCLES(RSTC)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .r_key(r_key), .r_ctr(r_ctr),
        .r_in_valid(r_in_valid), .r_in_ready(r_in_ready), .r_in_block(r_in_block),
        .r_out_valid(r_out_valid), .r_out_ready(r_out_ready), .r_out_block(r_out_block),
        .aes_key(aes_key), .aes_ctr(aes_ctr),
        .aes_in_valid(aes_in_valid), .aes_in_ready(aes_in_ready), .aes_in_block(aes_in_block),
        .aes_out_valid(aes_out_valid), .aes_out_ready(aes_out_ready), .aes_out_block(aes_out_block),
        .aes_fifo_empty(aes_fifo_empty), .aes_rst(aes_rst)
`ifdef AES_ARB_STATS_EN
        , .blk_cnt0(blk_cnt0), .blk_cnt1(blk_cnt1), .switch_cnt(switch_cnt)
`endif
    );

    function automatic logic [127:0] model_f(input logic [255:0] k, input logic [127:0] c,
                                             input logic [127:0] b);
        return b ^ k[255:128] ^ {k[63:0], k[127:64]} ^ c;
    endfunction

    // Stand-in engine: 4-deep FIFO applying model_f, with random input stalls.
    logic [127:0] e_mem [4];
    logic [1:0]   e_wp = 2'd0;
    logic [1:0]   e_rp = 2'd0;
    logic [2:0]   e_cnt = 3'd0;
    logic         e_stall = 1'b0;
    logic         e_push;
    logic         e_pop;

    assign aes_in_ready   = (e_cnt < 3'd4) && !aes_rst && !e_stall;
    assign aes_out_valid  = (e_cnt != 3'd0);
    assign aes_out_block  = e_mem[e_rp];
    assign aes_fifo_empty = (e_cnt == 3'd0);
    assign e_push = aes_in_valid && aes_in_ready;
    assign e_pop  = aes_out_valid && aes_out_ready;

    always @(posedge clk) begin
        e_stall <= ($urandom_range(0, 3) == 0);
        if (aes_rst) begin
            e_cnt <= 3'd0;
            e_wp  <= 2'd0;
            e_rp  <= 2'd0;
        end else begin
            if (e_push) begin
                e_mem[e_wp] <= model_f(aes_key, aes_ctr, aes_in_block);
                e_wp <= e_wp + 2'd1;
            end
            if (e_pop) begin
                e_rp <= e_rp + 2'd1;
            end
            e_cnt <= e_cnt + 3'(e_push) - 3'(e_pop);
        end
    end

    typedef struct packed {
        logic         id;
        logic [127:0] val;
    } sb_t;

    sb_t          sb [$];
    int           glog [$];
    int           checks = 0;
    int           failures = 0;
    int           left [2];
    int           idx [2];
    int           n_outs [2];
    bit           drop_sent [2];
    bit           drop_done [2];
    logic [127:0] ctr_base [2];
    int           viol = 0;
    int           rst_pulses = 0;
    bit           prev_gnt = 1'b0;
    bit           prev_rst = 1'b1;

    function automatic bit pending(input int i);
        foreach (sb[k]) if (sb[k].id == i[0]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_req();
        for (int i = 0; i < 2; i++) begin
            r_in_valid[i] = (left[i] > 0) && req[i];
            r_in_block[i*128 +: 128] = {32'(i) ^ 32'hC0DE_0000, 32'(idx[i]),
                                        64'h0123_4567_89AB_CDEF ^ 64'(idx[i] * 7)};
            r_ctr[i*128 +: 128] = ctr_base[i] + 128'(idx[i]);
        end
    endtask

    task automatic clear_bench();
        for (int i = 0; i < 2; i++) begin
            left[i] = 0; idx[i] = 0; n_outs[i] = 0;
            drop_sent[i] = 1'b0; drop_done[i] = 1'b0;
        end
        sb.delete();
        glog.delete();
        viol = 0;
        rst_pulses = 0;
    endtask

    // Called at a negedge; samples handshakes just before the next posedge.
    task automatic step();
        bit in_hs [2];
        sb_t e;
        #4;
        for (int i = 0; i < 2; i++) begin
            if (r_out_valid[i] && !gnt[i]) viol++;
            if (r_out_valid[i] && r_out_ready[i]) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL out_unexpected req%0d got %h required nothing", i, r_out_block);
                end else begin
                    e = sb.pop_front();
                    if (e.id != i[0] || r_out_block !== e.val) begin
                        failures++;
                        $display("FAIL out_data req%0d got %h required %h (for req%0d)",
                                 i, r_out_block, e.val, e.id);
                    end
                    n_outs[i]++;
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            in_hs[i] = r_in_valid[i] && r_in_ready[i];
            if (in_hs[i]) begin
                e.id  = i[0];
                e.val = model_f(r_key[i*256 +: 256], r_ctr[i*128 +: 128], r_in_block[i*128 +: 128]);
                sb.push_back(e);
            end
        end
        if (r_out_valid == 2'b11) viol++;
        @(posedge clk);
        #1;
        if (gnt != 2'b00 && !prev_gnt) glog.push_back(int'(gnt[1]));
        prev_gnt = |gnt;
        if (aes_rst && !prev_rst) rst_pulses++;
        prev_rst = aes_rst;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (in_hs[i]) begin idx[i]++; left[i]--; end
            if (drop_sent[i] && left[i] == 0) req[i] = 1'b0;
            if (drop_done[i] && left[i] == 0 && !pending(i)) req[i] = 1'b0;
        end
        drive_req();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks += 6;
        if (gnt !== 2'b00) begin failures++; $display("FAIL rst_gnt got %b required 00", gnt); end
        if (aes_rst !== 1'b1) begin failures++; $display("FAIL rst_aes_rst got %b required 1", aes_rst); end
        if (r_in_ready !== 2'b00) begin failures++; $display("FAIL rst_in_ready got %b required 00", r_in_ready); end
        if (r_out_valid !== 2'b00) begin failures++; $display("FAIL rst_out_valid got %b required 00", r_out_valid); end
        if (aes_in_valid !== 1'b0) begin failures++; $display("FAIL rst_aes_in_valid got %b required 0", aes_in_valid); end
        if (aes_out_ready !== 1'b0) begin failures++; $display("FAIL rst_aes_out_ready got %b required 0", aes_out_ready); end
        rst = 1'b0;
        step();
        checks += 2;
        if (aes_rst !== 1'b0) begin failures++; $display("FAIL idle_aes_rst got %b required 0", aes_rst); end
        if (gnt !== 2'b00) begin failures++; $display("FAIL idle_gnt got %b required 00", gnt); end
    endtask

    task automatic test_single();
        int n = 0;
        int rcnt = 0;
        clear_bench();
        r_key = {256'hFEED_FACE_0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD, 256'h0};
        ctr_base[0] = 128'h0;
        left[0] = 4;
        drop_done[0] = 1'b1;
        req = 2'b01;
        drive_req();
        while (n < 20) begin
            step();
            n++;
            if (aes_rst) rcnt++;
            if (gnt == 2'b01) break;
        end
        checks += 2;
        if (n != RSTC + 1) begin failures++; $display("FAIL single_gnt_latency got %0d required %0d", n, RSTC + 1); end
        if (rcnt != RSTC) begin failures++; $display("FAIL single_aes_rst_cycles got %0d required %0d", rcnt, RSTC); end
        n = 0;
        while (n < 300 && (gnt != 2'b00 || req != 2'b00)) begin step(); n++; end
        checks += 4;
        if (gnt !== 2'b00) begin failures++; $display("FAIL single_idle_timeout gnt got %b required 00", gnt); end
        if (n_outs[0] != 4) begin failures++; $display("FAIL single_out_count got %0d required 4", n_outs[0]); end
        if (glog.size() != 1) begin failures++; $display("FAIL single_saturated_grants got %0d required 1", glog.size()); end
        if (viol != 0) begin failures++; $display("FAIL single_nonowner_out got %0d required 0", viol); end
    endtask

    task automatic test_drain_stall();
        int n = 0;
        int bad = 0;
        clear_bench();
        r_key = {256'h1357_9BDF_2468_ACE0_1111_2222_3333_4444_5555_6666_7777_8888_9999_0000_ABCD_EF01,
                 256'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100_1F1E_1D1C_1B1A_1918_1716_1514_1312_1110};
        ctr_base[0] = 128'h1000;
        ctr_base[1] = 128'h2000;
        left[0] = 2; drop_sent[0] = 1'b1;
        left[1] = 1; drop_done[1] = 1'b1;
        r_out_ready = 2'b10;
        req = 2'b01;
        drive_req();
        while (n < 100 && left[0] != 0) begin step(); n++; end
        req[1] = 1'b1;
        drive_req();
        for (int k = 0; k < 20; k++) begin
            step();
            if (gnt !== 2'b01 || r_in_ready !== 2'b00) bad++;
        end
        checks += 2;
        if (left[0] != 0) begin failures++; $display("FAIL drain_inputs_timeout got %0d required 0", left[0]); end
        if (bad != 0) begin failures++; $display("FAIL drain_hold cycles_wrong got %0d required 0", bad); end
        r_out_ready = 2'b11;
        n = 0;
        while (n < 100 && gnt != 2'b10) begin step(); n++; end
        checks += 3;
        if (gnt !== 2'b10) begin failures++; $display("FAIL drain_switch_timeout gnt got %b required 10", gnt); end
        if (n_outs[0] != 2) begin failures++; $display("FAIL drain_req0_outs got %0d required 2", n_outs[0]); end
        if (pending(0)) begin failures++; $display("FAIL drain_req0_pending got 1 required 0"); end
        n = 0;
        while (n < 200 && (gnt != 2'b00 || req != 2'b00)) begin step(); n++; end
        checks += 2;
        if (n_outs[1] != 1) begin failures++; $display("FAIL drain_req1_outs got %0d required 1", n_outs[1]); end
        if (viol != 0) begin failures++; $display("FAIL drain_nonowner_out got %0d required 0", viol); end
    endtask

    task automatic test_async_reset();
        int n = 0;
        clear_bench();
        left[0] = 8;
        req = 2'b01;
        drive_req();
        while (n < 20 && gnt != 2'b01) begin step(); n++; end
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        checks += 4;
        if (gnt !== 2'b00) begin failures++; $display("FAIL arst_gnt got %b required 00", gnt); end
        if (aes_rst !== 1'b1) begin failures++; $display("FAIL arst_aes_rst got %b required 1", aes_rst); end
        if (r_in_ready !== 2'b00) begin failures++; $display("FAIL arst_in_ready got %b required 00", r_in_ready); end
        if (aes_in_valid !== 1'b0) begin failures++; $display("FAIL arst_aes_in_valid got %b required 0", aes_in_valid); end
        @(negedge clk);
        @(negedge clk);
        clear_bench();
        req = 2'b00;
        drive_req();
        checks += 1;
        if (aes_rst !== 1'b1) begin failures++; $display("FAIL arst_hold_aes_rst got %b required 1", aes_rst); end
        rst = 1'b0;
        step();
        step();
        checks += 2;
        if (gnt !== 2'b00) begin failures++; $display("FAIL arst_idle_gnt got %b required 00", gnt); end
        if (aes_rst !== 1'b0) begin failures++; $display("FAIL arst_idle_aes_rst got %b required 0", aes_rst); end
    endtask

    task automatic test_burst_yield();
        int n = 0;
        clear_bench();
        prev_rst = aes_rst;
        prev_gnt = |gnt;
        ctr_base[0] = 128'hAAAA_0000;
        ctr_base[1] = 128'hBBBB_0000;
        left[0] = 6; drop_done[0] = 1'b1;
        left[1] = 6; drop_done[1] = 1'b1;
        req = 2'b11;
        drive_req();
        while (n < 3000 && (gnt != 2'b00 || req != 2'b00)) begin step(); n++; end
        checks += 5;
        if (req != 2'b00 || gnt != 2'b00) begin failures++; $display("FAIL burst_timeout req %b gnt %b required 00", req, gnt); end
        if (glog.size() != 6) begin failures++; $display("FAIL burst_grant_count got %0d required 6", glog.size()); end
        if (rst_pulses != 6) begin failures++; $display("FAIL burst_aes_rst_pulses got %0d required 6", rst_pulses); end
        if (n_outs[0] != 6 || n_outs[1] != 6) begin
            failures++; $display("FAIL burst_out_counts got %0d/%0d required 6/6", n_outs[0], n_outs[1]);
        end
        if (viol != 0) begin failures++; $display("FAIL burst_nonowner_out got %0d required 0", viol); end
        for (int k = 0; k < glog.size() && k < 6; k++) begin
            checks++;
            if (glog[k] != k % 2) begin failures++; $display("FAIL burst_grant_seq[%0d] got %0d required %0d", k, glog[k], k % 2); end
        end
`ifdef AES_ARB_STATS_EN
        checks += 3;
        if (blk_cnt0 !== 32'd6) begin failures++; $display("FAIL stats_blk_cnt0 got %0d required 6", blk_cnt0); end
        if (blk_cnt1 !== 32'd6) begin failures++; $display("FAIL stats_blk_cnt1 got %0d required 6", blk_cnt1); end
        if (switch_cnt !== 16'd6) begin failures++; $display("FAIL stats_switch_cnt got %0d required 6", switch_cnt); end
`endif
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_bench();
        ctr_base[0] = '0;
        ctr_base[1] = '0;
        drive_req();
        @(negedge clk);
        test_reset();
        test_single();
        test_drain_stall();
        test_async_reset();
        test_burst_yield();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aes_engine_arbiter.md
Name: aes_engine_arbiter

Overview:
- Shares one aes256_fifo engine between two requesters (e.g. the crypto_accel register front-end and a future DMA streamer).
- Only one requester owns the engine at a time, so all in-flight blocks belong to the current owner and outputs route back without tags.
- Ownership changes drain the pipeline, then pulse aes_rst for a clean key/counter load.
- Sits between the requesters and aes256_fifo and drives its key, ctr, block handshakes and reset.

Parameters:
- MAX_BURST, 16, input blocks accepted per grant before yielding to a pending other requester (1..255).
- RST_CYCLES, 2, cycles aes_rst is held during an ownership switch (1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req  in  2  per-requester session request, level; req[i] held while requester i wants the engine
- gnt  out  2  one-hot current owner; 0 when idle or switching
- r_key  in  2x256  per-requester AES key, packed {r1,r0}
- r_ctr  in  2x128  per-requester counter, packed
- r_in_valid  in  2  per-requester input block valid
- r_in_ready  out  2  per-requester input block ready
- r_in_block  in  2x128  per-requester input block, packed
- r_out_valid  out  2  per-requester output valid
- r_out_ready  in  2  per-requester output ready
- r_out_block  out  128  shared output block; qualify with r_out_valid
- aes_key  out  256  to engine
- aes_ctr  out  128  to engine
- aes_in_valid  out  1  to engine
- aes_in_ready  in  1  from engine
- aes_in_block  out  128  to engine
- aes_out_valid  in  1  from engine
- aes_out_ready  out  1  to engine
- aes_out_block  in  128  from engine
- aes_fifo_empty  in  1  engine has no blocks in pipeline or output buffer
- aes_rst  out  1  engine reset

Behaviour:
- Reset values: state=IDLE, owner=0, gnt=0, burst count=0, aes_rst=1, all r_in_ready/r_out_valid=0, aes_in_valid=0, aes_out_ready=0.
- States:
  - IDLE: aes_rst=0. If any req, pick the winner, load owner, go to SWITCH. Both requesting: requester 0 wins after reset; afterwards the requester that did not own last wins (round-robin).
  - SWITCH: aes_rst=1 for RST_CYCLES cycles, then go to ACTIVE with gnt=onehot(owner). Burst count clears.
  - ACTIVE: aes_key/aes_ctr combinationally mux to the owner's r_key/r_ctr. aes_in_valid=r_in_valid[owner]; r_in_ready[owner]=aes_in_ready. The non-owner's ready is 0. Each input handshake increments the burst count, saturating at MAX_BURST.
  - DRAIN: entered from ACTIVE when !req[owner], or when burst count == MAX_BURST and req[other]. Input readies are 0; output routing continues. When aes_fifo_empty=1 and no output is mid-handshake, go to SWITCH if req[other], else to SWITCH with owner kept if req[owner], else IDLE. gnt stays asserted through DRAIN.
- Output path is active in ACTIVE and DRAIN: r_out_valid[owner]=aes_out_valid, aes_out_ready=r_out_ready[owner], r_out_block=aes_out_block. The non-owner's r_out_valid is 0.
- Input accepted on the same cycle DRAIN is entered: the handshake on that edge completes and counts; no further inputs are taken.
- Burst limit with no other request: the count stays saturated and the owner keeps the engine.
- Owner drops req with outputs outstanding: the outputs are still delivered before the switch.
- rst mid-operation: immediate return to reset values. In-flight engine data is lost; aes_rst stays asserted while rst=1.
- No combinational path from aes_in_ready to aes_in_valid.

Optional Feature:
- Macro AES_ARB_STATS_EN.
- Defined: adds outputs blk_cnt0 and blk_cnt1 (32 bits each, wrapping) counting input handshakes per requester, plus switch_cnt (16 bits) counting SWITCH entries. All clear on rst.
- Undefined: these ports and registers are absent.

Decomposition:
- Shared package aes_arb_pkg:
  - state encoding (IDLE, SWITCH, ACTIVE, DRAIN)
  - AES_KEY_W=256, AES_BLK_W=128
- One natural sub-module, aes_arb_rr: two-way round-robin picker taking req and last owner, returning the winner.
- Datapath muxing stays in the top level.

Test Plan:
- Single requester: req=01, 4 blocks with key 0, ctr 0, auto-increment done by the requester. Required: gnt=01 after RST_CYCLES; outputs equal the crypto_accel vectors 81a2b418_54de42b0… in order on r_out_valid[0].
- Burst yield: MAX_BURST=2, both req held, each offers 6 blocks. Required: grant sequence 0,1,0,1,0,1; aes_rst pulses between grants; no output ever appears on the non-owner.
- Drain with stalled output: r_out_ready[0]=0 for 20 cycles after req[0] drops. Required: state stays in DRAIN, gnt=01, and requester 1 is not granted until the 0-side outputs are consumed and aes_fifo_empty=1.
- Simultaneous first request: req=11 out of reset. Required: requester 0 granted first. Next contest: requester 1 wins.
- Async reset mid-burst: assert rst between clock edges in ACTIVE. Required: gnt=0 and aes_rst=1 immediately; IDLE after release.
- Stats (AES_ARB_STATS_EN): the burst-yield scenario gives blk_cnt0=6, blk_cnt1=6, switch_cnt=6.
